// File: rtl/ddr_bank_pkg.sv
// Shared types and constants for the DDR burst data bank.
// State encoding, fixed pipeline depths and a width helper.
package ddr_bank_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrPre,
    StWrBurst,
    StWrPost,
    StRdWait,
    StRdBurst
  } bank_state_e;

  localparam int unsigned PREAMBLE_CYCLES  = 1;
  localparam int unsigned POSTAMBLE_CYCLES = 1;
  // IDDR capture stage plus the output register.
  localparam int unsigned RD_PIPE_DELAY    = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ddr_bit_io.sv
// One DQ bit: SAME_EDGE ODDR, tristate pad buffer and SAME_EDGE IDDR.
// Beat 0 travels in the high clock phase, beat 1 in the low phase.
module ddr_bit_io (
  input  logic clk,
  input  logic t,
  input  logic d0,
  input  logic d1,
  output logic q0,
  output logic q1,
  inout  wire  io
);

  logic oq0;
  logic oq1;
  logic obit;
  logic rise_q;

  always_ff @(posedge clk) begin
    oq0 <= d0;
    oq1 <= d1;
  end

  assign obit = clk ? oq0 : oq1;
  assign io   = t ? 1'bz : obit;

  // Rising beat is caught at the falling edge, then both beats re-aligned to the rising edge.
  always_ff @(negedge clk) begin
    rise_q <= io;
  end

  always_ff @(posedge clk) begin
    q0 <= rise_q;
    q1 <= io;
  end

endmodule

// File: rtl/ddr_burst_bank.sv
// DDR data bank: burst sequencing, DQ direction control and read-latency alignment.
// Optional data-mask output enabled by defining DDR_BURST_BANK_DM_EN.
module ddr_burst_bank
  import ddr_bank_pkg::*;
#(
  parameter int unsigned LANES        = 2,
  parameter int unsigned LANE_WIDTH   = 8,
  parameter int unsigned BURST_CYCLES = 2,
  parameter int unsigned LAT_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_start,
  input  logic                        rd_start,
  input  logic [LAT_W-1:0]            rd_lat,
  input  logic [LANES*LANE_WIDTH-1:0] wr_d0,
  input  logic [LANES*LANE_WIDTH-1:0] wr_d1,
`ifdef DDR_BURST_BANK_DM_EN
  input  logic [LANES-1:0]            wr_m0,
  input  logic [LANES-1:0]            wr_m1,
  output logic [LANES-1:0]            dm,
`endif
  output logic                        wr_req,
  output logic [LANES*LANE_WIDTH-1:0] rd_q0,
  output logic [LANES*LANE_WIDTH-1:0] rd_q1,
  output logic                        rd_valid,
  output logic                        rd_done,
  output logic                        busy,
  inout  wire  [LANES*LANE_WIDTH-1:0] io
);

  localparam int unsigned DW    = LANES * LANE_WIDTH;
  localparam int unsigned CNT_W = clog2(PREAMBLE_CYCLES + BURST_CYCLES + POSTAMBLE_CYCLES);

  localparam logic [CNT_W-1:0] PreLast   = CNT_W'(PREAMBLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PostLast  = CNT_W'(POSTAMBLE_CYCLES - 1);

  bank_state_e      state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             t_q;
  logic             wr_req_q;

  logic [RD_PIPE_DELAY-1:0] valid_pipe_q;
  logic [RD_PIPE_DELAY-1:0] done_pipe_q;
  logic                     cap_win;
  logic                     cap_last;
  logic                     drain;

  logic [DW-1:0] oddr_d0_q;
  logic [DW-1:0] oddr_d1_q;
  logic [DW-1:0] iddr_q0;
  logic [DW-1:0] iddr_q1;
  logic [DW-1:0] rd_q0_q;
  logic [DW-1:0] rd_q1_q;

  assign cap_win  = (state_q == StRdBurst);
  assign cap_last = cap_win && (beat_cnt_q == BurstLast);
  // Read data still in flight after the FSM is back in idle.
  assign drain    = |valid_pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
      t_q        <= 1'b1;
      wr_req_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          t_q      <= 1'b1;
          wr_req_q <= 1'b0;
          if (!drain) begin
            if (wr_start) begin
              state_q    <= StWrPre;
              beat_cnt_q <= '0;
              t_q        <= 1'b0;
              wr_req_q   <= (PREAMBLE_CYCLES == 1);
            end else if (rd_start) begin
              state_q   <= StRdWait;
              lat_cnt_q <= rd_lat;
            end
          end
        end
        StWrPre: begin
          if (beat_cnt_q == PreLast) begin
            state_q    <= StWrBurst;
            beat_cnt_q <= '0;
            wr_req_q   <= (BURST_CYCLES > 1);
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            wr_req_q   <= (beat_cnt_q + 1'b1 == PreLast);
          end
        end
        StWrBurst: begin
          if (beat_cnt_q == BurstLast) begin
            state_q    <= StWrPost;
            beat_cnt_q <= '0;
            wr_req_q   <= 1'b0;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // The last burst cycle consumes nothing: its data was taken in the preamble.
            wr_req_q   <= (beat_cnt_q + 1'b1 != BurstLast);
          end
        end
        StWrPost: begin
          if (beat_cnt_q == PostLast) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            t_q        <= 1'b1;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        StRdWait: begin
          if (lat_cnt_q == '0) begin
            state_q    <= StRdBurst;
            beat_cnt_q <= '0;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        StRdBurst: begin
          if (beat_cnt_q == BurstLast) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          beat_cnt_q <= '0;
          t_q        <= 1'b1;
          wr_req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe_q <= '0;
      done_pipe_q  <= '0;
      rd_q0_q      <= '0;
      rd_q1_q      <= '0;
    end else begin
      valid_pipe_q <= {valid_pipe_q[RD_PIPE_DELAY-2:0], cap_win};
      done_pipe_q  <= {done_pipe_q[RD_PIPE_DELAY-2:0], cap_last};
      if (valid_pipe_q[RD_PIPE_DELAY-2]) begin
        rd_q0_q <= iddr_q0;
        rd_q1_q <= iddr_q1;
      end
    end
  end

  // ODDR input register; zero outside consumed cycles gives the low preamble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oddr_d0_q <= '0;
      oddr_d1_q <= '0;
    end else begin
      oddr_d0_q <= wr_req_q ? wr_d0 : '0;
      oddr_d1_q <= wr_req_q ? wr_d1 : '0;
    end
  end

  for (genvar i = 0; i < DW; i++) begin : g_bit
    ddr_bit_io u_bit (
      .clk (clk),
      .t   (t_q),
      .d0  (oddr_d0_q[i]),
      .d1  (oddr_d1_q[i]),
      .q0  (iddr_q0[i]),
      .q1  (iddr_q1[i]),
      .io  (io[i])
    );
  end

`ifdef DDR_BURST_BANK_DM_EN
  logic [LANES-1:0] m0_q;
  logic [LANES-1:0] m1_q;
  logic [LANES-1:0] dm_r0_q;
  logic [LANES-1:0] dm_r1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_q    <= '0;
      m1_q    <= '0;
      dm_r0_q <= '0;
      dm_r1_q <= '0;
    end else begin
      m0_q    <= wr_req_q ? wr_m0 : '0;
      m1_q    <= wr_req_q ? wr_m1 : '0;
      dm_r0_q <= m0_q;
      dm_r1_q <= m1_q;
    end
  end

  assign dm = clk ? dm_r0_q : dm_r1_q;
`else
  // No mask pins in this build; the board ties DM low.
`endif

  assign wr_req   = wr_req_q;
  assign rd_q0    = rd_q0_q;
  assign rd_q1    = rd_q1_q;
  assign rd_valid = valid_pipe_q[RD_PIPE_DELAY-1];
  assign rd_done  = done_pipe_q[RD_PIPE_DELAY-1];
  assign busy     = (state_q != StIdle) | drain;

endmodule

// File: tb/tb_ddr_burst_bank.sv
// Directed bench for ddr_burst_bank: write/read bursts, start arbitration,
// busy gating and asynchronous reset during a read.
module tb_ddr_burst_bank;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          wr_start;
  logic          rd_start;
  logic [3:0]    rd_lat;
  logic [DW-1:0] wr_d0;
  logic [DW-1:0] wr_d1;
  logic          wr_req;
  logic [DW-1:0] rd_q0;
  logic [DW-1:0] rd_q1;
  logic          rd_valid;
  logic          rd_done;
  logic          busy;
  wire  [DW-1:0] io;
  logic          drv_en;
  logic [DW-1:0] drv_val;
`ifdef DDR_BURST_BANK_DM_EN
  logic [1:0]    wr_m0;
  logic [1:0]    wr_m1;
  logic [1:0]    dm;
`endif

  int n_checks;
  int n_fail;
  int t_low_cnt;
  int wr_req_cnt;
  int rd_valid_cnt;
  int rd_done_cnt;

  assign io = drv_en ? drv_val : {DW{1'bz}};

  ddr_burst_bank dut (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_start),
    .rd_start (rd_start),
    .rd_lat   (rd_lat),
    .wr_d0    (wr_d0),
    .wr_d1    (wr_d1),
`ifdef DDR_BURST_BANK_DM_EN
    .wr_m0    (wr_m0),
    .wr_m1    (wr_m1),
    .dm       (dm),
`endif
    .wr_req   (wr_req),
    .rd_q0    (rd_q0),
    .rd_q1    (rd_q1),
    .rd_valid (rd_valid),
    .rd_done  (rd_done),
    .busy     (busy),
    .io       (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and update cycle monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dut.t_q === 1'b0) t_low_cnt++;
    if (wr_req === 1'b1) wr_req_cnt++;
    if (rd_valid === 1'b1) rd_valid_cnt++;
    if (rd_done === 1'b1) rd_done_cnt++;
  endtask

  task automatic clear_counts();
    t_low_cnt    = 0;
    wr_req_cnt   = 0;
    rd_valid_cnt = 0;
    rd_done_cnt  = 0;
  endtask

  // Called just after a rising edge: drive both beats of one capture cycle.
  task automatic pad_cycle(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    drv_en  = 1'b1;
    drv_val = b0;
    @(negedge clk);
    #1 drv_val = b1;
    tick();
  endtask

  // Called just after a rising edge: sample both beats the DUT drives this cycle.
  task automatic pad_expect(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    #1 check({tag, "_beat0"}, 32'(io), 32'(e0));
    @(negedge clk);
    #2 check({tag, "_beat1"}, 32'(io), 32'(e1));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_counts();
    rst      = 1'b1;
    wr_start = 1'b0;
    rd_start = 1'b0;
    rd_lat   = '0;
    wr_d0    = '0;
    wr_d1    = '0;
    drv_en   = 1'b0;
    drv_val  = '0;
`ifdef DDR_BURST_BANK_DM_EN
    wr_m0    = '0;
    wr_m1    = '0;
`endif

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_q0", 32'(rd_q0), 32'd0);
    check("rst_rd_q1", 32'(rd_q1), 32'd0);
    check("rst_t", 32'(dut.t_q), 32'd1);
    rst = 1'b0;
    tick();

    // Write burst: preamble cycle then one burst cycle consume data
    clear_counts();
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_req_pre", 32'(wr_req), 32'd1);
    check("wr_t_pre", 32'(dut.t_q), 32'd0);
    wr_d0 = 16'h1111;
    wr_d1 = 16'h2222;
`ifdef DDR_BURST_BANK_DM_EN
    wr_m0 = 2'b01;
    wr_m1 = 2'b00;
`endif
    tick();
    check("wr_req_b0", 32'(wr_req), 32'd1);
    wr_d0 = 16'h3333;
    wr_d1 = 16'h4444;
`ifdef DDR_BURST_BANK_DM_EN
    wr_m0 = 2'b00;
`endif
    tick();
    check("wr_req_b1", 32'(wr_req), 32'd0);
    wr_d0 = 16'hdead;
    wr_d1 = 16'hbeef;
`ifdef DDR_BURST_BANK_DM_EN
    #1 check("dm_beat0", 32'(dm), 32'h1);
    #0;
    @(negedge clk);
    #2 check("dm_beat1", 32'(dm), 32'h0);
    @(posedge clk);
    #1;
    if (dut.t_q === 1'b0) t_low_cnt++;
    #1 check("dm_b_beat0", 32'(dm), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    if (dut.t_q === 1'b0) t_low_cnt++;
    wr_d0 = '0;
    wr_d1 = '0;
    // Replay of the pad data is not possible here; the mask build checks mask alignment only.
    check("wr_busy_after", 32'(busy), 32'd0);
`else
    pad_expect("wr_a", 16'h1111, 16'h2222);
    tick();
    pad_expect("wr_b", 16'h3333, 16'h4444);
    tick();
    wr_d0 = '0;
    wr_d1 = '0;
    check("wr_busy_after", 32'(busy), 32'd0);
`endif
    check("wr_t_after", 32'(dut.t_q), 32'd1);
    check("wr_t_low_cycles", 32'(t_low_cnt), 32'd4);
    check("wr_req_cycles", 32'(wr_req_cnt), 32'd2);
    tick();

    // Read burst, latency 3; rd_lat changes after acceptance must not matter
    clear_counts();
    rd_lat   = 4'd3;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_lat   = 4'd9;
    check("rd_busy_wait", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    check("rd_valid_early", 32'(rd_valid), 32'd0);
    tick();
    pad_cycle(16'haaaa, 16'h5555);
    pad_cycle(16'h0f0f, 16'hf0f0);
    drv_en = 1'b0;
    check("rd1_valid", 32'(rd_valid), 32'd1);
    check("rd1_q0", 32'(rd_q0), 32'haaaa);
    check("rd1_q1", 32'(rd_q1), 32'h5555);
    check("rd1_done", 32'(rd_done), 32'd0);
    tick();
    check("rd2_valid", 32'(rd_valid), 32'd1);
    check("rd2_q0", 32'(rd_q0), 32'h0f0f);
    check("rd2_q1", 32'(rd_q1), 32'hf0f0);
    check("rd2_done", 32'(rd_done), 32'd1);
    check("rd2_busy", 32'(busy), 32'd1);
    tick();
    check("rd_end_valid", 32'(rd_valid), 32'd0);
    check("rd_end_busy", 32'(busy), 32'd0);
    check("rd_valid_cycles", 32'(rd_valid_cnt), 32'd2);
    check("rd_t_never_low", 32'(t_low_cnt), 32'd0);

    // Simultaneous starts: write wins, read dropped
    clear_counts();
    wr_start = 1'b1;
    rd_start = 1'b1;
    rd_lat   = 4'd0;
    tick();
    wr_start = 1'b0;
    rd_start = 1'b0;
    check("both_wr_req", 32'(wr_req), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("both_no_rd_valid", 32'(rd_valid_cnt), 32'd0);
    check("both_wr_req_cycles", 32'(wr_req_cnt), 32'd2);
    check("both_t_low_cycles", 32'(t_low_cnt), 32'd4);
    check("both_busy_end", 32'(busy), 32'd0);

    // rd_start while a write is in progress is ignored
    clear_counts();
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("ign_busy_b1", 32'(busy), 32'd1);
    tick();
    check("ign_busy_post", 32'(busy), 32'd1);
    tick();
    check("ign_busy_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("ign_no_rd_valid", 32'(rd_valid_cnt), 32'd0);

    // Asynchronous reset in the middle of a read burst
    clear_counts();
    rd_lat   = 4'd0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_rd_valid_rst", 32'(rd_valid), 32'd0);
    check("mid_t_rst", 32'(dut.t_q), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_no_rd_valid", 32'(rd_valid_cnt), 32'd0);
    check("mid_no_rd_done", 32'(rd_done_cnt), 32'd0);

    // Read with latency 0 after the reset; a write pulse during the drain is ignored
    clear_counts();
    rd_lat   = 4'd0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    pad_cycle(16'h1234, 16'h5678);
    pad_cycle(16'h9abc, 16'hdef0);
    drv_en = 1'b0;
    check("lat0_valid1", 32'(rd_valid), 32'd1);
    check("lat0_q0_1", 32'(rd_q0), 32'h1234);
    check("lat0_q1_1", 32'(rd_q1), 32'h5678);
    check("lat0_busy_drain", 32'(busy), 32'd1);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    check("lat0_q0_2", 32'(rd_q0), 32'h9abc);
    check("lat0_q1_2", 32'(rd_q1), 32'hdef0);
    check("lat0_done", 32'(rd_done), 32'd1);
    tick();
    check("lat0_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("lat0_drain_wr_ignored", 32'(t_low_cnt), 32'd0);
    check("lat0_done_count", 32'(rd_done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
